gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
- Synthesizable self-checking counterpart to the lab's 2-input gate benches, placed on the receive side of the DUT.
- On `start`, drives the four input vectors 00, 01, 10, 11 onto the DUT, each held for `HOLD_CYCLES` clocks.
- Samples the DUT's two response bits at the end of each hold window and compares them to parameterised truth tables.
- Reports pass/fail, an error count and a per-vector fail mask, so the lab board can self-test without a simulator.

Parameters:
- `HOLD_CYCLES`, default 10: clocks each vector is held; legal range 2..255.
- `EXP_Y`, default 4'b1000: expected `rsp_y` truth table; bit index = {a,b}; the default is AND.
- `EXP_X`, default 4'b1110: expected `rsp_x` truth table; bit index = {a,b}; the default is OR.
- `ERR_W`, default 4: width of the error counter.

Ports:
- `clk`  in  1  single system clock; all logic rising-edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins a sweep when idle or done.
- `stim_a`  out  1  DUT input a.
- `stim_b`  out  1  DUT input b.
- `rsp_y`  in  1  DUT response y.
- `rsp_x`  in  1  DUT response x.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep end until the next start or reset.
- `pass`  out  1  valid when `done`=1; 1 if no mismatches.
- `err_count`  out  `ERR_W`  number of mismatching vectors; saturates at all-ones.
- `fail_vec`  out  4  bit i set if vector i ({a,b}=i) mismatched.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of `clk`. All of the following are 0 after reset: `stim_a`, `stim_b`, `busy`, `done`, `pass`, `err_count`, `fail_vec`, vector index, hold counter. State returns to IDLE.
- Reset asserted mid-sweep aborts immediately on that edge; no partial result is kept.
- States:
  - IDLE: outputs held at reset values. `start` → DRIVE with idx=0, cnt=0, `err_count`=0, `fail_vec`=0, `busy`=1, `done`=0.
  - DRIVE: {`stim_a`,`stim_b`} = idx, registered and updated on the same edge idx changes.
    - cnt increments each clock.
    - When cnt == `HOLD_CYCLES`-1: compare `rsp_y` against `EXP_Y`[idx] and `rsp_x` against `EXP_X`[idx]. If either differs, set `fail_vec`[idx] and increment `err_count`, saturating; a vector counts at most once.
    - Then: if idx<3, idx+1 and cnt=0, staying in DRIVE; if idx==3, go to DONE.
  - DONE: stim forced back to 00 (mirrors the trailing 00 of the manual benches). `busy`=0, `done`=1, `pass` = (`err_count`==0). Holds until `start` → DRIVE, which clears results as in IDLE.
- `start` while `busy` is ignored.
- Latency:
  - The DUT gets `HOLD_CYCLES`-1 clocks after a stimulus change before sampling, so a combinational or single-register DUT is fine.
  - Sweep length: 4·`HOLD_CYCLES` clocks from the `start` edge to `done` rising.
- Simultaneous `start` and reset low: reset wins.
- `rsp_*` are sampled only on compare cycles; values at other times are don't-care.
- X on `rsp_*` at a compare cycle counts as a mismatch in simulation. Use `!==` in an assertion only; RTL uses `!=`.

Optional Feature:
- Macro: `GATE_CHK_STOP_ON_FAIL_EN`.
- Defined: on the first mismatch the sweep aborts to DONE on the next edge. Remaining vectors are not driven, `err_count`=1, `fail_vec` has exactly that bit set, and `pass`=0.
- Undefined: all four vectors are always swept and every mismatch is counted.

Test Plan:
1. Correct AND/OR DUT, `HOLD_CYCLES`=10, `start` at cycle 5 → stim 00,01,10,11 each for 10 clocks; `done`=1 at cycle 45; `pass`=1, `err_count`=0, `fail_vec`=0000; stim back to 00.
2. DUT with y stuck-at-0 → `fail_vec`=1000, `err_count`=1, `pass`=0. Also with y stuck-at-1 → `fail_vec`=0111, `err_count`=3.
3. Macro `GATE_CHK_STOP_ON_FAIL_EN` defined, x inverted → abort after the first hold window; `done` at cycle `start`+10; `fail_vec`=0001, `err_count`=1.
4. Pulse `start` again at cycle 20 mid-sweep → ignored; completion timing is identical to scenario 1. Assert `rst_n`=0 at cycle 25 → next edge: `busy`=0, `done`=0, stim 00.
5. `ERR_W`=1 with a fully inverted DUT → `err_count` saturates at 1; `fail_vec`=1111; `pass`=0.
6. DUT with one register stage, `HOLD_CYCLES`=2 → `pass`=1. Hold `start` high for 3 cycles → exactly one sweep begins.

Source files
------------

// File: rtl/gate_response_checker.sv
// gate_response_checker: sweeps 00,01,10,11 into a 2-input gate DUT and checks y/x.
// Optional `GATE_CHK_STOP_ON_FAIL_EN: abort the sweep on the first mismatching vector.
module gate_response_checker #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [3:0]  EXP_Y       = 4'b1000,
    parameter logic [3:0]  EXP_X       = 4'b1110,
    parameter int unsigned ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             stim_a,
    output logic             stim_b,
    input  logic             rsp_y,
    input  logic             rsp_x,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       stim_q, stim_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    logic cmp;
    logic mismatch;
    logic stop_now;

    // Compare cycle: last clock of the current hold window.
    always_comb begin
        cmp      = (state_q == S_DRIVE) && (cnt_q == LAST);
        mismatch = 1'b0;
        if (cmp) begin
            // if/else so an unknown response falls into the mismatch branch
            if ((rsp_y == EXP_Y[idx_q]) && (rsp_x == EXP_X[idx_q]))
                mismatch = 1'b0;
            else
                mismatch = 1'b1;
        end
    end

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // Next-state and next-value logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        err_d   = err_q;
        fail_d  = fail_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    stim_d  = 2'd0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            S_DRIVE: begin
                cnt_d = cnt_q + 8'd1;
                if (cmp) begin
                    if (mismatch) begin
                        fail_d[idx_q] = 1'b1;
                        if (err_q != '1)
                            err_d = err_q + ERR_W'(1);
                    end
                    if ((idx_q == 2'd3) || stop_now) begin
                        state_d = S_DONE;
                        idx_d   = 2'd0;
                        cnt_d   = 8'd0;
                        stim_d  = 2'd0;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        cnt_d  = 8'd0;
                        stim_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            stim_q  <= 2'd0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

`ifndef SYNTHESIS
    // Flag unknown responses on compare cycles.
    always @(posedge clk) begin
        if (rst_n && cmp)
            assert (!(({rsp_y, rsp_x} ^ {rsp_y, rsp_x}) !== 2'b00));
    end
`endif

    assign stim_a    = stim_q[1];
    assign stim_b    = stim_q[0];
    assign busy      = (state_q == S_DRIVE);
    assign done      = (state_q == S_DONE);
    assign pass      = (state_q == S_DONE) && (err_q == '0);
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: two checker instances against modelled gate DUTs.
// Unit 0: defaults, combinational DUT. Unit 1: HOLD_CYCLES=2, ERR_W=1, registered DUT.
module tb_gate_response_checker;

    localparam int H0 = 10;
    localparam int H1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic [3:0] fy0 = 4'b0;
    logic [3:0] fx0 = 4'b0;
    logic [3:0] fy1 = 4'b0;
    logic [3:0] fx1 = 4'b0;
    logic ry0, rx0;
    logic ry1 = 1'b0;
    logic rx1 = 1'b0;

    wire sa0, sb0, bz0, dn0, ps0;
    wire sa1, sb1, bz1, dn1, ps1;
    wire [3:0] ec0, fv0, fv1;
    wire [0:0] ec1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate DUT 0: AND on y, OR on x, with per-vector flip masks.
    always_comb begin
        ry0 = (sa0 & sb0) ^ fy0[{sa0, sb0}];
        rx0 = (sa0 | sb0) ^ fx0[{sa0, sb0}];
    end

    // Gate DUT 1: same function behind one register stage.
    always @(posedge clk) begin
        ry1 <= (sa1 & sb1) ^ fy1[{sa1, sb1}];
        rx1 <= (sa1 | sb1) ^ fx1[{sa1, sb1}];
    end

    gate_response_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .stim_a(sa0), .stim_b(sb0),
        .rsp_y(ry0), .rsp_x(rx0),
        .busy(bz0), .done(dn0), .pass(ps0),
        .err_count(ec0), .fail_vec(fv0)
    );

    gate_response_checker #(
        .HOLD_CYCLES(H1),
        .ERR_W(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .stim_a(sa1), .stim_b(sb1),
        .rsp_y(ry1), .rsp_x(rx1),
        .busy(bz1), .done(dn1), .pass(ps1),
        .err_count(ec1), .fail_vec(fv1)
    );

    typedef struct {
        string      nm;
        logic [3:0] fy;
        logic [3:0] fx;
        logic [3:0] f;
        int         e;
    } row_t;

    row_t rows[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Mismatch mask actually recorded: all of them, or only the first.
    function automatic logic [3:0] eff(input logic [3:0] f);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        return f & (~f + 4'd1);
`else
        return f;
`endif
    endfunction

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic snap(input int u, output logic [1:0] st,
                        output logic b, output logic d,
                        output logic p, output logic [3:0] e,
                        output logic [3:0] f);
        if (u == 0) begin
            st = {sa0, sb0}; b = bz0; d = dn0;
            p = ps0; e = ec0; f = fv0;
        end else begin
            st = {sa1, sb1}; b = bz1; d = dn1;
            p = ps1; e = {3'b0, ec1}; f = fv1;
        end
    endtask

    task automatic set_start(input int u, input logic v);
        if (u == 0) start0 = v;
        else start1 = v;
    endtask

    // One sweep; called and returns at a negedge. hold_edges: edges start
    // stays high; extra_edge: a later edge with start pulsed again.
    task automatic sweep(input int u, input string nm,
                         input logic [3:0] my, input logic [3:0] mx,
                         input logic [3:0] exp_f, input int exp_e,
                         input int hold_edges, input int extra_edge);
        int h;
        int d_edge;
        int first;
        logic [1:0] st;
        logic b, d, p;
        logic [3:0] e, f;
        h = (u == 0) ? H0 : H1;
        first = 4;
        for (int i = 3; i >= 0; i--)
            if (exp_f[i]) first = i;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        d_edge = (first == 4) ? 4 * h : (first + 1) * h;
`else
        d_edge = 4 * h;
`endif
        if (u == 0) begin
            fy0 = my; fx0 = mx;
        end else begin
            fy1 = my; fx1 = mx;
        end
        set_start(u, 1'b1);
        for (int k = 0; k <= d_edge; k++) begin
            @(negedge clk);
            set_start(u, ((k + 1) < hold_edges) || ((k + 1) == extra_edge));
            snap(u, st, b, d, p, e, f);
            if (k < d_edge) begin
                if (b !== 1'b1 || d !== 1'b0)
                    chk({nm, " busy_done"}, {b, d}, 2'b10);
                else
                    checks++;
                chk({nm, " stim"}, st, k / h);
            end else begin
                chk({nm, " end_busy"}, b, 0);
                chk({nm, " end_done"}, d, 1);
                chk({nm, " end_stim"}, st, 0);
                chk({nm, " pass"}, p, exp_f == 4'b0);
                chk({nm, " err_count"}, e, exp_e);
                chk({nm, " fail_vec"}, f, exp_f);
            end
        end
        set_start(u, 1'b0);
    endtask

    initial begin
        logic [1:0] st;
        logic b, d, p;
        logic [3:0] e, f, my, mx, ef;
        int ee;

        rows[0] = '{"and_or_ok", 4'b0000, 4'b0000, 4'b0000, 0};
        rows[1] = '{"y_stuck0",  4'b1000, 4'b0000, 4'b1000, 1};
        rows[2] = '{"y_stuck1",  4'b0111, 4'b0000, 4'b0111, 3};
        rows[3] = '{"x_inv",     4'b0000, 4'b1111, 4'b1111, 4};
        rows[4] = '{"all_inv",   4'b1111, 4'b1111, 4'b1111, 4};
        rows[5] = '{"x_stuck1",  4'b0000, 4'b0001, 4'b0001, 1};
        rows[6] = '{"mixed",     4'b0100, 4'b0010, 4'b0110, 2};
        rows[7] = '{"ok_again",  4'b0000, 4'b0000, 4'b0000, 0};

        // Reset wins over a simultaneous start.
        rst_n = 1'b0;
        start0 = 1'b1;
        start1 = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            snap(u, st, b, d, p, e, f);
            chk("rst stim", st, 0);
            chk("rst busy", b, 0);
            chk("rst done", d, 0);
            chk("rst pass", p, 0);
            chk("rst err", e, 0);
            chk("rst fail", f, 0);
        end
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            ef = eff(rows[r].f);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
            ee = (rows[r].f != 4'b0) ? 1 : 0;
`else
            ee = rows[r].e;
`endif
            sweep(0, rows[r].nm, rows[r].fy, rows[r].fx, ef, ee, 1, -1);
            sweep(1, rows[r].nm, rows[r].fy, rows[r].fx, ef, sat(ee, 1), 1, -1);
        end

        // Second start mid-sweep is ignored; timing unchanged.
        sweep(0, "restart_ignored", 4'b0, 4'b0, 4'b0, 0, 1, 15);

        // Start held three cycles launches exactly one sweep.
        sweep(1, "hold_start", 4'b0, 4'b0, 4'b0, 0, 3, -1);
        @(negedge clk);
        chk("hold_start stays_done", dn1, 1);
        chk("hold_start no_rerun", bz1, 0);

        for (int n = 0; n < 8; n++) begin
            my = 4'($urandom_range(0, 15));
            mx = 4'($urandom_range(0, 15));
            ef = eff(my | mx);
            sweep(0, "rand0", my, mx, ef, sat($countones(ef), 4), 1, -1);
            sweep(1, "rand1", my, mx, ef, sat($countones(ef), 1), 1, -1);
        end

        // Reset in the middle of a failing sweep drops everything.
        fy0 = 4'b1111;
        fx0 = 4'b0000;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst fail0", fv0[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst busy", bz0, 0);
        chk("mid_rst done", dn0, 0);
        chk("mid_rst stim", {sa0, sb0}, 0);
        chk("mid_rst err", ec0, 0);
        chk("mid_rst fail", fv0, 0);
        chk("mid_rst done1", dn1, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst idle", {bz0, dn0}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
